demux_2ch_deserializer: RTL

- Downstream stage of the 1x2 bit demux. Consumes the demux's 2-lane output y[1:0] plus the select s that drove it.
- Samples only the lane that s selects, so the unselected high-Z lane is never read.
- Packs each lane's bit stream into W-bit words, one shift register per channel.
- Presents the completed words per channel with a valid/ready handshake and a sticky overflow flag.

---
 rtl/demux_2ch_deserializer_pkg.sv | 7 +
 rtl/demux_2ch_deserializer_lane.sv | 78 +++++++
 rtl/demux_2ch_deserializer.sv | 54 +++++
 3 files changed

// File: rtl/demux_2ch_deserializer_pkg.sv
// Shared defaults for the 2-channel demux deserializer.
package demux_2ch_deserializer_pkg;

  localparam int DESER_W_DEFAULT         = 8;
  localparam bit DESER_LSB_FIRST_DEFAULT = 1'b1;

endpackage

// File: rtl/demux_2ch_deserializer_lane.sv
// One deserializer channel: shift register, bit counter, output word register,
// valid/ready handshake and sticky overflow.
module deser_lane
  import demux_2ch_deserializer_pkg::*;
#(
  parameter int W         = DESER_W_DEFAULT,
  parameter bit LSB_FIRST = DESER_LSB_FIRST_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_take,
  input  logic         i_bit,
  input  logic         i_sync,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_ovf
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [W-1:0]     r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_data;
  logic             r_valid;
  logic             r_ovf;

  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_pos;
  logic [W-1:0]     w_word;
  logic             w_done;
  logic             w_load;

  // sync restarts the frame on this very edge, so a bit taken with it is bit 0
  assign w_cnt_base = i_sync ? '0 : r_cnt;
  assign w_pos      = LSB_FIRST ? w_cnt_base : (CNT_LAST - w_cnt_base);
  assign w_done     = i_take && (w_cnt_base == CNT_LAST);
  assign w_load     = w_done && (!r_valid || i_ready);

  always_comb begin
    w_word        = r_shift;
    w_word[w_pos] = i_bit;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_take) begin
      r_shift <= w_word;
      r_cnt   <= (w_cnt_base == CNT_LAST) ? '0 : w_cnt_base + 1'b1;
    end else if (i_sync) begin
      r_cnt   <= '0;
    end
  end

  // A completed word is dropped only when the held word is not leaving this edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
    end else if (w_done) begin
      r_ovf   <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/demux_2ch_deserializer.sv
// Deserializer behind the 1x2 bit demux: only the selected lane is sampled and
// each channel packs its bits into W-bit words.
module demux_2ch_deserializer
  import demux_2ch_deserializer_pkg::*;
#(
  parameter int W         = DESER_W_DEFAULT,
  parameter bit LSB_FIRST = DESER_LSB_FIRST_DEFAULT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic           i_s,
  input  logic [1:0]     i_y,
  input  logic           i_sync,
  output logic [2*W-1:0] o_out_data,
  output logic [1:0]     o_out_valid,
  input  logic [1:0]     i_out_ready,
  output logic [1:0]     o_ovf
);

  logic         w_bit;
  logic [W-1:0] w_data0;
  logic [W-1:0] w_data1;

  // The idle demux lane floats; the mux keeps it out of the datapath
  assign w_bit = i_s ? i_y[1] : i_y[0];

  deser_lane #(.W(W), .LSB_FIRST(LSB_FIRST)) u_lane0 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_take  (i_en & ~i_s),
    .i_bit   (w_bit),
    .i_sync  (i_sync),
    .i_ready (i_out_ready[0]),
    .o_data  (w_data0),
    .o_valid (o_out_valid[0]),
    .o_ovf   (o_ovf[0])
  );

  deser_lane #(.W(W), .LSB_FIRST(LSB_FIRST)) u_lane1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_take  (i_en & i_s),
    .i_bit   (w_bit),
    .i_sync  (i_sync),
    .i_ready (i_out_ready[1]),
    .o_data  (w_data1),
    .o_valid (o_out_valid[1]),
    .o_ovf   (o_ovf[1])
  );

  assign o_out_data = {w_data1, w_data0};

endmodule
